// File: rtl/nios_system_switches_debounce_ctrl.sv
// Avalon-MM switch/button input port: per-bit 2-flop synchroniser, counter debounce,
// sticky edge capture with W1C, and a maskable registered level interrupt.
module nios_system_switches_debounce_ctrl #(
    parameter int WIDTH       = 8,
    parameter int LIMIT_W     = 20,
    parameter int DEB_DEFAULT = 500000,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0]   sync1_q, sync1_d;
    logic [WIDTH-1:0]   sync2_q, sync2_d;
    logic [WIDTH-1:0]   stable_q, stable_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   edge_q, edge_d;
    logic [LIMIT_W-1:0] limit_q, limit_d;
    logic [LIMIT_W-1:0] cnt_q [WIDTH];
    logic [LIMIT_W-1:0] cnt_d [WIDTH];
    logic [31:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic               wr_en;
    logic [LIMIT_W-1:0] limit_m1;
    logic [WIDTH-1:0]   rise, fall, edge_set, edge_clr;
    logic               unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;
    // A LIMIT of 0 debounces like 1; the >= compare lets a lowered limit fire at once.
    assign limit_m1     = (limit_q == '0) ? '0 : limit_q - LIMIT_W'(1);

    always_comb begin
        sync1_d  = in_port;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= limit_m1) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + LIMIT_W'(1);
                end
            end
        end

        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
        if (EDGE_TYPE == 1) begin
            edge_set = rise;
        end else if (EDGE_TYPE == 2) begin
            edge_set = fall;
        end else begin
            edge_set = rise | fall;
        end

        edge_clr = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : '0;
        edge_d   = (edge_q & ~edge_clr) | edge_set;
        mask_d   = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : mask_q;
        limit_d  = (wr_en && address == 2'd3) ? writedata[LIMIT_W-1:0] : limit_q;
        irq_d    = |(edge_q & mask_q);

        case (address)
            2'd0:    readdata_d = 32'(stable_q);
            2'd1:    readdata_d = 32'(mask_q);
            2'd2:    readdata_d = 32'(edge_q);
            default: readdata_d = 32'(limit_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            limit_q    <= LIMIT_W'(DEB_DEFAULT);
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            limit_q    <= limit_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_system_switches_debounce_ctrl.sv
// Directed bench for the switch debounce controller: an any-edge instance and a
// rising-edge-only instance share the same bus and pins.
module tb_nios_system_switches_debounce_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata, readdata_r;
    logic        irq, irq_r;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nios_system_switches_debounce_ctrl #(.EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    nios_system_switches_debounce_ctrl #(.EDGE_TYPE(1)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_r), .irq(irq_r)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        in_port    = 8'hFF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        tick(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        // Release reset and set LIMIT=4 on the first edge after release.
        reset_n = 1'b1;
        wr(2'd3, 32'd4);
        address = 2'd0;
        for (int i = 2; i <= 7; i++) begin
            tick(1);
            chk($sformatf("post_reset_data_e%0d", i), readdata, (i == 7) ? 32'hFF : 32'h0);
        end
        rd(2'd2);
        chk("post_reset_edge", readdata, 32'hFF);
        chk("post_reset_edge_r", readdata_r, 32'hFF);
        chk("post_reset_irq", {31'h0, irq}, 32'h0);
        rd(2'd1);
        chk("reset_mask", readdata, 32'h0);

        // Return all pins low, clear edges, then a 3-cycle glitch on bit0.
        in_port = 8'h00;
        tick(12);
        wr(2'd2, 32'hFF);
        rd(2'd0);
        chk("low_data", readdata, 32'h0);
        rd(2'd2);
        chk("edge_cleared", readdata, 32'h0);
        in_port = 8'h01;
        tick(3);
        in_port = 8'h00;
        tick(10);
        rd(2'd0);
        chk("glitch_data", readdata, 32'h0);
        rd(2'd2);
        chk("glitch_edge", readdata, 32'h0);

        // Held pulse: STABLE updates exactly 6 edges after the pin change.
        address = 2'd0;
        in_port = 8'h01;
        tick(6);
        chk("pulse_data_before", readdata, 32'h0);
        in_port = 8'h00;
        tick(1);
        chk("pulse_data_after", readdata, 32'h1);
        tick(12);

        // Interrupt: set on edge, cleared by W1C, then dropped by masking.
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'h01);
        in_port = 8'h01;
        tick(6);
        chk("irq_before_edge", {31'h0, irq}, 32'h0);
        tick(1);
        chk("irq_after_edge", {31'h0, irq}, 32'h1);
        wr(2'd2, 32'h01);
        chk("irq_w1c_same", {31'h0, irq}, 32'h1);
        tick(1);
        chk("irq_w1c_drop", {31'h0, irq}, 32'h0);
        in_port = 8'h00;
        tick(10);
        chk("irq_fall_edge", {31'h0, irq}, 32'h1);
        wr(2'd1, 32'h00);
        chk("irq_mask_same", {31'h0, irq}, 32'h1);
        tick(1);
        chk("irq_mask_drop", {31'h0, irq}, 32'h0);

        // Rising-only capture on bit3.
        in_port = 8'h08;
        tick(10);
        wr(2'd2, 32'hFF);
        in_port = 8'h00;
        tick(10);
        rd(2'd2);
        chk("fall_edge_r", readdata_r, 32'h0);
        chk("fall_edge_any", readdata, 32'h08);
        in_port = 8'h08;
        tick(10);
        rd(2'd2);
        chk("rise_edge_r", readdata_r, 32'h08);

        // W1C of EDGE[2] on the same edge that STABLE[2] rises: set wins.
        wr(2'd2, 32'hFF);
        in_port = 8'h0C;
        tick(5);
        wr(2'd2, 32'h04);
        rd(2'd2);
        chk("set_wins", readdata, 32'h04);
        chk("set_wins_r", readdata_r, 32'h04);

        // LIMIT=0 debounces like LIMIT=1.
        wr(2'd3, 32'h0);
        address = 2'd0;
        in_port = 8'h0E;
        tick(3);
        chk("limit0_before", readdata, 32'h0C);
        tick(1);
        chk("limit0_after", readdata, 32'h0E);
        rd(2'd3);
        chk("limit0_read", readdata, 32'h0);

        // Readback, upper-bit zeroing and ignored DATA write.
        wr(2'd3, 32'hFFFABCDE);
        rd(2'd3);
        chk("limit_read", readdata, 32'h000ABCDE);
        wr(2'd1, 32'hFFFFFFFF);
        rd(2'd1);
        chk("mask_read", readdata, 32'h000000FF);
        wr(2'd0, 32'h00000000);
        rd(2'd0);
        chk("data_write_ignored", readdata, 32'h0E);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
